gated_event_counter: RTL

GATED_EVENT_COUNTER -- requirements
Module: gated_event_counter

---
 rtl/gated_counter_pkg.sv | 17 +
 rtl/sync_edge_detect.sv | 36 +++
 rtl/gated_event_counter.sv | 119 +++++++++++
 3 files changed

// File: rtl/gated_counter_pkg.sv
// rtl/gated_counter_pkg.sv - shared state encoding and default constants for the gated event counter
package gated_counter_pkg;

    // FSM state encoding shared by the counter and anything that observes it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Default parameter values: 7-bit result feeding a two-digit display,
    // 1000-cycle gate window, saturate at 99.
    localparam int DEF_WIDTH       = 7;
    localparam int DEF_GATE_CYCLES = 1000;
    localparam int DEF_MAX_COUNT   = 99;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer with rising-edge detect
//
// Purpose: bring an asynchronous pulse into the clk domain and flag each
//          rising edge for exactly one cycle.
// Ports:
//   clk       - sampling clock
//   rstN      - asynchronous active-low reset, clears all flops
//   asyncIn   - asynchronous input
//   risePulse - high for one cycle when the synchronized input goes 0->1
module sync_edge_detect (
    input  logic clk,
    input  logic rstN,
    input  logic asyncIn,
    output logic risePulse
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= asyncIn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Decoded from flops only, so the pulse is glitch-free inside the clk domain.
    assign risePulse = sync2 & ~sync3;

endmodule

// File: rtl/gated_event_counter.sv
// rtl/gated_event_counter.sv - counts event pulses over fixed gate windows and latches the result
//
// Purpose: count rising edges of eventIn during back-to-back windows of
//          GATE_CYCLES clk cycles, saturating at MAX_COUNT, and present the
//          last completed window on registered outputs.
// Ports:
//   clk        - single clock
//   rstN       - asynchronous active-low reset
//   eventIn    - asynchronous event pulses
//   enable     - synchronous run control; high runs consecutive windows
//   validCount - count of the last completed window, held between latches
//   countValid - one-cycle pulse while the freshly latched count is presented
//   overflow   - last latched window saw an edge after reaching MAX_COUNT
module gated_event_counter
    import gated_counter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int MAX_COUNT   = DEF_MAX_COUNT
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             eventIn,
    input  logic             enable,
    output logic [WIDTH-1:0] validCount,
    output logic             countValid,
    output logic             overflow
);

    localparam int               TW        = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0]    LAST_TICK = TW'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_COUNT);

    state_t           state;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] event_cnt;
    logic             ovf_seen;
    logic             rise;

    sync_edge_detect u_sync (
        .clk       (clk),
        .rstN      (rstN),
        .asyncIn   (eventIn),
        .risePulse (rise)
    );

    // Saturating next count, including an edge detected this very cycle so
    // the final COUNT cycle is not lost when latching.
    logic             at_max;
    logic [WIDTH-1:0] cnt_next;
    logic             ovf_next;

    assign at_max   = (event_cnt == MAX_VAL);
    assign cnt_next = (rise && !at_max) ? event_cnt + 1'b1 : event_cnt;
    // Overflow means an edge arrived while already saturated; it stays set
    // for the rest of the window once seen.
    assign ovf_next = ovf_seen | (rise & at_max);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            timer      <= '0;
            event_cnt  <= '0;
            ovf_seen   <= 1'b0;
            validCount <= '0;
            countValid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            countValid <= 1'b0;
            case (state)
                IDLE: begin
                    // Edges seen here are dropped; a new window starts clean.
                    if (enable) begin
                        state     <= COUNT;
                        timer     <= '0;
                        event_cnt <= '0;
                        ovf_seen  <= 1'b0;
                    end
                end

                COUNT: begin
                    if (!enable) begin
                        // Abort: discard the partial window, keep the last result.
                        state     <= IDLE;
                        timer     <= '0;
                        event_cnt <= '0;
                        ovf_seen  <= 1'b0;
                    end else if (timer == LAST_TICK) begin
                        state      <= LATCH;
                        timer      <= '0;
                        validCount <= cnt_next;
                        overflow   <= ovf_next;
                        countValid <= 1'b1;
                    end else begin
                        timer     <= timer + 1'b1;
                        event_cnt <= cnt_next;
                        ovf_seen  <= ovf_next;
                    end
                end

                LATCH: begin
                    // An edge landing in this cycle opens the next window's count.
                    event_cnt <= rise ? WIDTH'(1) : '0;
                    ovf_seen  <= 1'b0;
                    timer     <= '0;
                    state     <= enable ? COUNT : IDLE;
                end

                default: begin
                    state     <= IDLE;
                    timer     <= '0;
                    event_cnt <= '0;
                    ovf_seen  <= 1'b0;
                end
            endcase
        end
    end

endmodule
